// File: rtl/lia_pio_pkg.sv
// Shared definitions for the multi-channel lock-in capture port: register
// offsets, CONTROL/STATUS bit positions and the 32-bit extension helper.
package lia_pio_pkg;

    localparam int REG_STATUS  = 0;
    localparam int REG_CONTROL = 1;
    localparam int REG_COUNT   = 2;
    localparam int REG_CH_BASE = 8;

    localparam int ST_NEW     = 0;
    localparam int ST_OVERRUN = 1;

    localparam int CTL_SNAP      = 0;
    localparam int CTL_SNAP_MODE = 1;
    localparam int CTL_CNT_CLR   = 2;
    localparam int CTL_IRQ_EN    = 3;
    localparam int CTL_FREEZE    = 4;

    // Extend the low 'width' bits of data to 32 bits, sign- or zero-filled.
    function automatic logic [31:0] ext32(input logic [31:0] data, input int width,
                                          input logic sgn);
        logic [31:0] mask;
        logic        msb;
        mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'h1 << width) - 32'h1);
        msb  = |((data >> (width - 1)) & 32'h1);
        return (sgn && msb) ? (data | ~mask) : (data & mask);
    endfunction

endpackage

// File: rtl/lia_multi_capture_pio_chan.sv
// One captured channel: live register, snapshot register and the 32-bit
// extended readback of whichever bank is selected.
module lia_chan_reg
    import lia_pio_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int SIGNED = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic              snap,
    input  logic              sel_snap,
    input  logic [DATA_W-1:0] d,
    output logic [31:0]       q
);

    logic [DATA_W-1:0] live_q;
    logic [DATA_W-1:0] snap_q;
    logic [DATA_W-1:0] sel_p0;

    // Live bank follows accepted samples; snapshot copies the pre-edge live value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            live_q <= '0;
            snap_q <= '0;
        end else begin
            if (load) live_q <= d;
            if (snap) snap_q <= live_q;
        end
    end

    assign sel_p0 = sel_snap ? snap_q : live_q;
    assign q      = ext32(32'(sel_p0), DATA_W, SIGNED != 0);

endmodule

// File: rtl/lia_multi_capture_pio.sv
// Multi-channel lock-in result capture with coherent snapshot, NEW/OVERRUN
// status, sample counter and level interrupt behind an Avalon-MM slave.
module lia_multi_capture_pio
    import lia_pio_pkg::*;
#(
    parameter int NCH    = 8,
    parameter int DATA_W = 16,
    parameter int SIGNED = 1,
    parameter int ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_W-1:0]     address,
    input  logic                  read,
    input  logic                  write,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [NCH*DATA_W-1:0] in_data,
    input  logic                  in_valid,
    output logic                  irq
);

    logic        snap_mode, irq_en, freeze;
    logic        new_q, ovr_q;
    logic [31:0] count_q;
    logic [31:0] ch_rd [NCH];
    logic [31:0] rd_word_p0;

    logic wr_status, wr_ctl, rd_en, rd_status;
    logic accept, snap, cnt_clr, new_clr, w1c_ovr;

    assign wr_status = write && (address == ADDR_W'(REG_STATUS));
    assign wr_ctl    = write && (address == ADDR_W'(REG_CONTROL));
    // A write wins over a read presented in the same cycle.
    assign rd_en     = read && !write;
    assign rd_status = rd_en && (address == ADDR_W'(REG_STATUS));

    assign accept  = in_valid && !freeze;
    assign snap    = wr_ctl && writedata[CTL_SNAP];
    assign cnt_clr = wr_ctl && writedata[CTL_CNT_CLR];
    assign new_clr = rd_status || (wr_status && writedata[ST_NEW]);
    assign w1c_ovr = wr_status && writedata[ST_OVERRUN];

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        lia_chan_reg #(
            .DATA_W (DATA_W),
            .SIGNED (SIGNED)
        ) u_chan (
            .clk      (clk),
            .reset_n  (reset_n),
            .load     (accept),
            .snap     (snap),
            .sel_snap (snap_mode),
            .d        (in_data[k*DATA_W +: DATA_W]),
            .q        (ch_rd[k])
        );
    end

    // Control bits, counter, status flags and interrupt.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snap_mode <= 1'b0;
            irq_en    <= 1'b0;
            freeze    <= 1'b0;
            count_q   <= '0;
            new_q     <= 1'b0;
            ovr_q     <= 1'b0;
            irq       <= 1'b0;
        end else begin
            if (wr_ctl) begin
                snap_mode <= writedata[CTL_SNAP_MODE];
                irq_en    <= writedata[CTL_IRQ_EN];
                freeze    <= writedata[CTL_FREEZE];
            end
            if (cnt_clr)     count_q <= '0;
            else if (accept) count_q <= count_q + 32'd1;
            // Set wins over clear so a sample landing on the clearing read is not lost.
            if (accept)       new_q <= 1'b1;
            else if (new_clr) new_q <= 1'b0;
            if (accept && new_q && !new_clr) ovr_q <= 1'b1;
            else if (w1c_ovr)                ovr_q <= 1'b0;
            irq <= new_q && irq_en;
        end
    end

    // Register readback multiplexer.
    always_comb begin
        rd_word_p0 = '0;
        if (address == ADDR_W'(REG_STATUS)) begin
            rd_word_p0[ST_NEW]     = new_q;
            rd_word_p0[ST_OVERRUN] = ovr_q;
        end else if (address == ADDR_W'(REG_CONTROL)) begin
            rd_word_p0[CTL_SNAP_MODE] = snap_mode;
            rd_word_p0[CTL_IRQ_EN]    = irq_en;
            rd_word_p0[CTL_FREEZE]    = freeze;
        end else if (address == ADDR_W'(REG_COUNT)) begin
            rd_word_p0 = count_q;
        end
        for (int k = 0; k < NCH; k++) begin
            if (address == ADDR_W'(REG_CH_BASE + k)) rd_word_p0 = ch_rd[k];
        end
    end

    // --- stage p1: registered read data, held between reads ---
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)   readdata <= '0;
        else if (rd_en) readdata <= rd_word_p0;
    end

endmodule

// File: tb/tb_lia_multi_capture_pio.sv
// Randomised and directed bench for lia_multi_capture_pio with a register-level
// reference model and a read-data scoreboard.
module tb_lia_multi_capture_pio;

    localparam int NCH    = 8;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int DW     = NCH * DATA_W;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [ADDR_W-1:0] address = '0;
    logic              read = 1'b0;
    logic              write = 1'b0;
    logic [31:0]       writedata = '0;
    logic [31:0]       readdata;
    logic [DW-1:0]     in_data = '0;
    logic              in_valid = 1'b0;
    logic              irq;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] val;
    } exp_t;
    exp_t exp_q[$];

    // Reference model state: what a software view of the register map holds.
    logic [15:0] m_live [NCH];
    logic [15:0] m_snap [NCH];
    logic [31:0] m_count;
    bit m_new, m_ovr, m_mode, m_ien, m_frz, m_irq;

    lia_multi_capture_pio #(
        .NCH(NCH), .DATA_W(DATA_W), .SIGNED(1), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .read(read),
        .write(write), .writedata(writedata), .readdata(readdata),
        .in_data(in_data), .in_valid(in_valid), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    task automatic m_reset();
        for (int k = 0; k < NCH; k++) begin
            m_live[k] = '0;
            m_snap[k] = '0;
        end
        m_count = '0;
        m_new = 0; m_ovr = 0; m_mode = 0; m_ien = 0; m_frz = 0; m_irq = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [3:0] a);
        logic [15:0] v;
        if (a == 0) return {30'd0, m_ovr, m_new};
        if (a == 1) return {27'd0, m_frz, m_ien, 1'b0, m_mode, 1'b0};
        if (a == 2) return m_count;
        if (a >= 8) begin
            v = m_mode ? m_snap[a - 8] : m_live[a - 8];
            return 32'($signed(v));
        end
        return 32'd0;
    endfunction

    task automatic m_apply(input bit rd, input logic [3:0] a, input bit wr,
                           input logic [31:0] wd, input bit iv, input logic [DW-1:0] d);
        bit take, ctl, st, clr_new;
        take    = iv && !m_frz;
        ctl     = wr && a == 1;
        st      = wr && a == 0;
        clr_new = (rd && !wr && a == 0) || (st && wd[0]);
        m_irq   = m_new && m_ien;
        if (ctl && wd[0])
            for (int k = 0; k < NCH; k++) m_snap[k] = m_live[k];
        if (take)
            for (int k = 0; k < NCH; k++) m_live[k] = d[k*DATA_W +: DATA_W];
        if (take && m_new && !clr_new) m_ovr = 1;
        else if (st && wd[1])          m_ovr = 0;
        if (take)         m_new = 1;
        else if (clr_new) m_new = 0;
        if (ctl && wd[2]) m_count = 0;
        else if (take)    m_count = m_count + 1;
        if (ctl) begin
            m_mode = wd[1]; m_ien = wd[3]; m_frz = wd[4];
        end
    endtask

    // One bus/sample cycle: drive, predict, then check irq after the edge.
    task automatic step(input bit rd, input logic [3:0] a, input bit wr,
                        input logic [31:0] wd, input bit iv, input logic [DW-1:0] d);
        exp_t e;
        @(negedge clk);
        read = rd; address = a; write = wr; writedata = wd; in_valid = iv; in_data = d;
        if (rd && !wr) begin
            e.addr = a;
            e.val  = m_read(a);
            exp_q.push_back(e);
        end
        m_apply(rd, a, wr, wd, iv, d);
        @(posedge clk);
        #1;
        check("irq", {31'd0, irq}, {31'd0, m_irq});
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, '0);
    endtask
    task automatic rd(input logic [3:0] a);
        step(1, a, 0, 0, 0, '0);
    endtask
    task automatic wr(input logic [3:0] a, input logic [31:0] v);
        step(0, a, 1, v, 0, '0);
    endtask
    task automatic smp(input logic [DW-1:0] d);
        step(0, 0, 0, 0, 1, d);
    endtask

    function automatic logic [DW-1:0] ch0(input logic [15:0] v);
        logic [DW-1:0] d;
        d = {DW{1'b1}} ^ {DW{1'b1}};
        d[15:0] = v;
        d[127:112] = 16'hA5A5;
        return d;
    endfunction

    // Hold the sample counter at all-ones across one idle edge.
    task automatic force_count_max();
        @(negedge clk);
        read = 0; write = 0; in_valid = 0;
        force dut.count_q = 32'hFFFF_FFFF;
        m_apply(0, 0, 0, 0, 0, '0);
        m_count = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        release dut.count_q;
        check("irq", {31'd0, irq}, {31'd0, m_irq});
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) idle();
        check("scoreboard_drained", exp_q.size(), 0);
    endtask

    // Monitor: whenever a read is accepted, compare readdata one cycle later.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (reset_n && read && !write) begin
                #1;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_read: got 0x%08h with no expectation", readdata);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("read_addr%0d", e.addr), readdata, e.val);
                end
            end
        end
    end

    initial begin
        logic [DW-1:0] d;
        logic [31:0]   wd;
        int            sel;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_readdata", readdata, 32'd0);
        check("reset_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int a = 0; a < 16; a++) rd(4'(a));

        // Sign extension, counter and NEW read-clear.
        d = '0; d[15:0] = 16'h8001; d[127:112] = 16'h7FFF;
        smp(d);
        rd(8); rd(15); rd(2); rd(0); rd(0);

        // Snapshot coherency, then SNAP coinciding with a sample.
        smp(ch0(16'h1111));
        wr(1, 32'h3);
        smp(ch0(16'h2222));
        rd(8);
        wr(1, 32'h0);
        rd(8);
        step(0, 1, 1, 32'h3, 1, ch0(16'h3333));
        rd(8);
        wr(1, 32'h0);
        rd(8); rd(0);

        // Overrun and interrupt.
        wr(1, 32'h8);
        smp(ch0(16'h0001)); smp(ch0(16'h0002));
        idle();
        wr(0, 32'h2);
        rd(0); rd(0);
        idle();
        smp(ch0(16'h0003)); smp(ch0(16'h0004));
        rd(0); wr(0, 32'h2); rd(0);

        // Sample colliding with a STATUS read, then freeze.
        smp(ch0(16'h0005));
        step(1, 0, 0, 0, 1, ch0(16'h0006));
        rd(0); rd(0);
        wr(1, 32'h10);
        for (int i = 0; i < 5; i++) smp(ch0(16'hBEEF));
        rd(2); rd(8);
        wr(1, 32'h0);
        rd(8);

        // Counter wrap and clear-over-increment.
        force_count_max();
        smp(ch0(16'h0007));
        rd(2);
        force_count_max();
        step(0, 1, 1, 32'h4, 1, ch0(16'h0008));
        rd(2); rd(0);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < NCH; k++) d[k*DATA_W +: DATA_W] = 16'($urandom);
            sel = $urandom_range(0, 9);
            if (sel < 5) begin
                step(1, 4'($urandom_range(0, 15)), 0, 0, $urandom_range(0, 1) == 1, d);
            end else if (sel < 7) begin
                wd = $urandom & 32'h0F;
                if ($urandom_range(0, 7) == 0) wd[4] = 1'b1;
                step(0, 1, 1, wd, $urandom_range(0, 1) == 1, d);
            end else if (sel < 8) begin
                step(0, 0, 1, $urandom & 32'h3, $urandom_range(0, 1) == 1, d);
            end else begin
                step(0, 4'($urandom_range(0, 15)), 0, 0, 1, d);
            end
        end
        drain();

        // Asynchronous reset in the middle of activity.
        wr(1, 32'h0B);
        smp(ch0(16'h4321));
        step(1, 8, 0, 0, 0, '0);
        idle();
        drain();
        @(negedge clk);
        read = 0; write = 0; in_valid = 0;
        #2 reset_n = 1'b0;
        #1;
        check("midreset_readdata", readdata, 32'd0);
        check("midreset_irq", {31'd0, irq}, 32'd0);
        m_reset();
        @(negedge clk);
        reset_n = 1'b1;
        for (int a = 0; a < 16; a++) rd(4'(a));
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
